// File: rtl/dtmr_pipe_vote.sv
`default_nettype none
// ============================================================================
// Module      : dtmr_pipe_vote
// Description : Distributed-TMR pipelined bitwise operator (AND/OR/XOR).
//               Three independent domains, DEPTH triplicated register stages,
//               a per-domain 2-of-3 voter after every stage, final-stage
//               disagreement monitor and sticky saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dtmr_pipe_vote #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int OP    = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a_0,
    input  logic [WIDTH-1:0] in_a_1,
    input  logic [WIDTH-1:0] in_a_2,
    input  logic [WIDTH-1:0] in_b_0,
    input  logic [WIDTH-1:0] in_b_1,
    input  logic [WIDTH-1:0] in_b_2,
    input  logic             in_valid_0,
    input  logic             in_valid_1,
    input  logic             in_valid_2,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic             out_valid_0,
    output logic             out_valid_1,
    output logic             out_valid_2,
    output logic [2:0]       err_domain,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Per-domain operand views, so every domain can be handled by index.
    logic [WIDTH-1:0] w_a  [3];
    logic [WIDTH-1:0] w_b  [3];
    logic             w_v  [3];
    logic [WIDTH-1:0] w_op [3];

    // Stage registers hold {valid, data}; one word per stage per domain.
    logic [WIDTH:0]   r_stage [DEPTH][3];
    // Voted view of each stage, one voter per consuming domain.
    logic [WIDTH:0]   w_vote  [DEPTH][3];
    logic [2:0]       w_err;
    logic [CNT_W-1:0] r_cnt;

    assign w_a[0] = in_a_0;
    assign w_a[1] = in_a_1;
    assign w_a[2] = in_a_2;
    assign w_b[0] = in_b_0;
    assign w_b[1] = in_b_1;
    assign w_b[2] = in_b_2;
    assign w_v[0] = in_valid_0;
    assign w_v[1] = in_valid_1;
    assign w_v[2] = in_valid_2;

    // Operator selection is fixed at elaboration; each domain has its own copy.
    if (OP == 0) begin : g_op_and
        for (genvar d = 0; d < 3; d++) begin : g_dom
            assign w_op[d] = w_a[d] & w_b[d];
        end
    end else if (OP == 1) begin : g_op_or
        for (genvar d = 0; d < 3; d++) begin : g_dom
            assign w_op[d] = w_a[d] | w_b[d];
        end
    end else if (OP == 2) begin : g_op_xor
        for (genvar d = 0; d < 3; d++) begin : g_dom
            assign w_op[d] = w_a[d] ^ w_b[d];
        end
    end else begin : g_op_bad
        $error("dtmr_pipe_vote: OP must be 0 (AND), 1 (OR) or 2 (XOR)");
    end

    // Bitwise 2-of-3 voters: separate instance per domain so no single voter
    // failure can corrupt more than one downstream domain.
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        for (genvar d = 0; d < 3; d++) begin : g_voter
            assign w_vote[s][d] = (r_stage[s][0] & r_stage[s][1]) |
                                  (r_stage[s][0] & r_stage[s][2]) |
                                  (r_stage[s][1] & r_stage[s][2]);
        end
    end

    // Pipeline: stage 0 captures the raw operator result, later stages
    // capture the voted previous stage; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int d = 0; d < 3; d++) begin
                    r_stage[s][d] <= '0;
                end
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                r_stage[0][d] <= {w_v[d], w_op[d]};
            end
            for (int s = 1; s < DEPTH; s++) begin
                for (int d = 0; d < 3; d++) begin
                    r_stage[s][d] <= w_vote[s-1][d];
                end
            end
        end
    end

    // Final-stage monitor: a domain is flagged when any of its bits differs
    // from the majority, so several domains may be flagged at once.
    for (genvar d = 0; d < 3; d++) begin : g_mon
        assign w_err[d] = |(r_stage[DEPTH-1][d] ^ w_vote[DEPTH-1][d]);
    end

    // Saturating mismatch-cycle counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (err_clr) begin
            r_cnt <= '0;
        end else if ((w_err != 3'b000) && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_0       = w_vote[DEPTH-1][0][WIDTH-1:0];
    assign out_1       = w_vote[DEPTH-1][1][WIDTH-1:0];
    assign out_2       = w_vote[DEPTH-1][2][WIDTH-1:0];
    assign out_valid_0 = w_vote[DEPTH-1][0][WIDTH];
    assign out_valid_1 = w_vote[DEPTH-1][1][WIDTH];
    assign out_valid_2 = w_vote[DEPTH-1][2][WIDTH];
    assign err_domain  = w_err;
    assign err_count   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dtmr_pipe_vote.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtmr_pipe_vote
// Description : Self-checking bench for dtmr_pipe_vote. Three instances:
//               0 = AND/DEPTH2/CNT_W8, 1 = XOR/DEPTH1/CNT_W2, 2 = OR/DEPTH3/CNT_W8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtmr_pipe_vote;

    localparam int DEP [3] = '{2, 1, 3};
    localparam int OPS [3] = '{0, 2, 1};
    localparam int CW  [3] = '{8, 2, 8};

    logic       clk;
    logic       rst [3];
    logic       clr [3];
    logic [7:0] a   [3][3];
    logic [7:0] b   [3][3];
    logic       v   [3][3];
    logic [7:0] o   [3][3];
    logic       ov  [3][3];
    logic [2:0] ed  [3];
    logic [7:0] cnt [3];

    int n_chk;
    int n_fail;
    int cnt_exp [3];

    typedef struct {
        int         inst;
        logic [7:0] a0, a1, a2, bb;
        logic [2:0] vv;    // bit d = in_valid_d
        logic [7:0] eo;    // voted data, same on every domain
        logic [2:0] eov;
        logic [2:0] eed;
    } vec_t;

    vec_t vecs [10];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [CW[k]-1:0] w_cnt;
        dtmr_pipe_vote #(
            .WIDTH(8), .DEPTH(DEP[k]), .OP(OPS[k]), .CNT_W(CW[k])
        ) u_dut (
            .clk(clk), .rst(rst[k]),
            .in_a_0(a[k][0]), .in_a_1(a[k][1]), .in_a_2(a[k][2]),
            .in_b_0(b[k][0]), .in_b_1(b[k][1]), .in_b_2(b[k][2]),
            .in_valid_0(v[k][0]), .in_valid_1(v[k][1]), .in_valid_2(v[k][2]),
            .out_0(o[k][0]), .out_1(o[k][1]), .out_2(o[k][2]),
            .out_valid_0(ov[k][0]), .out_valid_1(ov[k][1]), .out_valid_2(ov[k][2]),
            .err_domain(ed[k]), .err_count(w_cnt), .err_clr(clr[k])
        );
        assign cnt[k] = 8'(w_cnt);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle(input int i);
        for (int d = 0; d < 3; d++) begin
            a[i][d] = 8'h00;
            b[i][d] = 8'h00;
            v[i][d] = 1'b0;
        end
    endtask

    task automatic chk_out(input int i, input string tag, input logic [7:0] eo,
                           input logic [2:0] eov, input logic [2:0] eed);
        chk({tag, " out"},       {8'h0, o[i][2], o[i][1], o[i][0]}, {8'h0, eo, eo, eo});
        chk({tag, " out_valid"}, {29'h0, ov[i][2], ov[i][1], ov[i][0]}, {29'h0, eov});
        chk({tag, " err_domain"}, {29'h0, ed[i]}, {29'h0, eed});
    endtask

    task automatic run_vec(input int n, input vec_t t);
        int i;
        string tag;
        i   = t.inst;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        a[i][0] = t.a0; a[i][1] = t.a1; a[i][2] = t.a2;
        for (int d = 0; d < 3; d++) begin
            b[i][d] = t.bb;
            v[i][d] = t.vv[d];
        end
        @(posedge clk);
        #1;
        set_idle(i);
        repeat (DEP[i] - 1) @(posedge clk);
        #1;
        chk_out(i, tag, t.eo, t.eov, t.eed);
        if (t.eed != 3'b000 && cnt_exp[i] < (1 << CW[i]) - 1)
            cnt_exp[i]++;
        @(posedge clk);
        #1;
        chk({tag, " err_count"}, {24'h0, cnt[i]}, cnt_exp[i]);
    endtask

    int seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            clr[i] = 1'b0;
            cnt_exp[i] = 0;
            set_idle(i);
        end

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_out(i, $sformatf("reset%0d", i), 8'h00, 3'b000, 3'b000);
            chk($sformatf("reset%0d err_count", i), {24'h0, cnt[i]}, 32'h0);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // ---------------- table-driven vectors ----------------
        //            inst a0     a1     a2     b      valid   exp_out eov     eed
        vecs[0] = '{0, 8'hF0, 8'hF0, 8'hF0, 8'h3C, 3'b111, 8'h30, 3'b111, 3'b000};
        vecs[1] = '{0, 8'hF0, 8'hFF, 8'hF0, 8'h3C, 3'b111, 8'h30, 3'b111, 3'b000};
        vecs[2] = '{0, 8'hAA, 8'hAA, 8'hAA, 8'h0F, 3'b000, 8'h0A, 3'b000, 3'b000};
        vecs[3] = '{0, 8'h55, 8'h55, 8'h55, 8'hFF, 3'b101, 8'h55, 3'b111, 3'b000};
        vecs[4] = '{1, 8'h00, 8'h00, 8'h01, 8'h00, 3'b111, 8'h00, 3'b111, 3'b100};
        vecs[5] = '{1, 8'h5A, 8'h5A, 8'h5A, 8'hFF, 3'b111, 8'hA5, 3'b111, 3'b000};
        vecs[6] = '{1, 8'h01, 8'h02, 8'h00, 8'h00, 3'b111, 8'h00, 3'b111, 3'b011};
        vecs[7] = '{1, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 3'b011, 8'h00, 3'b111, 3'b100};
        vecs[8] = '{2, 8'h0F, 8'h0F, 8'h0F, 8'hA0, 3'b101, 8'hAF, 3'b111, 3'b000};
        vecs[9] = '{2, 8'h00, 8'h00, 8'h00, 8'h00, 3'b111, 8'h00, 3'b111, 3'b000};
        for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

        // ---------------- saturation and clear priority (CNT_W=2) ----------------
        @(negedge clk);
        clr[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("sat pre-clear err_count", {24'h0, cnt[1]}, 32'h0);
        clr[1] = 1'b0;
        a[1][0] = 8'h01;
        for (int d = 0; d < 3; d++) v[1][d] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat edge%0d err_domain", k), {29'h0, ed[1]}, 32'h1);
            if (k >= 2)
                chk($sformatf("sat edge%0d err_count", k), {24'h0, cnt[1]}, seq[k-2]);
        end
        clr[1] = 1'b1;
        a[1][0] = 8'h00;
        @(posedge clk);
        #1;
        chk("clr over inc err_count", {24'h0, cnt[1]}, 32'h0);
        chk("clr over inc err_domain", {29'h0, ed[1]}, 32'h0);
        clr[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("post-clr err_count", {24'h0, cnt[1]}, 32'h0);
        set_idle(1);

        // ---------------- reset mid-stream (DEPTH=3) ----------------
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                a[2][d] = 8'(i);
                b[2][d] = 8'h00;
                v[2][d] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk_out(2, "stream head", 8'h01, 3'b111, 3'b000);
        @(negedge clk);
        for (int d = 0; d < 3; d++) a[2][d] = 8'h04;
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        chk_out(2, "midrst", 8'h00, 3'b000, 3'b000);
        chk("midrst err_count", {24'h0, cnt[2]}, 32'h0);
        @(negedge clk);
        rst[2] = 1'b0;
        set_idle(2);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("no stale %0d out_valid", k),
                {29'h0, ov[2][2], ov[2][1], ov[2][0]}, 32'h0);
            chk($sformatf("no stale %0d out", k),
                {8'h0, o[2][2], o[2][1], o[2][0]}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtmr_pipe_vote.md
# dtmr_pipe_vote

Parametrised distributed-TMR pipelined operator: three independent domains each compute a bitwise AND/OR/XOR of two WIDTH-bit operands. The result passes through DEPTH triplicated register stages, with a per-domain majority voter after every stage, so a single-domain upset is scrubbed at each stage boundary. The final stage is monitored for domain disagreement, feeding a sticky, saturating error counter. It is the multi-bit, multi-stage successor of the single-bit DTMR operator cells and sits between a triplicated producer and a triplicated consumer.

## Interface
Parameters:
- WIDTH, 8, operand/result width (>=1)
- DEPTH, 2, number of triplicated register stages (>=1); latency in cycles
- OP, 0, operation: 0 = AND, 1 = OR, 2 = XOR; other values illegal (elaboration error)
- CNT_W, 8, error counter width (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_a_0 / in_a_1 / in_a_2  in  WIDTH  operand A, domains 0/1/2
- in_b_0 / in_b_1 / in_b_2  in  WIDTH  operand B, domains 0/1/2
- in_valid_0 / in_valid_1 / in_valid_2  in  1  qualifier, domains 0/1/2
- out_0 / out_1 / out_2  out  WIDTH  voted result, domains 0/1/2
- out_valid_0 / out_valid_1 / out_valid_2  out  1  voted qualifier, domains 0/1/2
- err_domain  out  3  bit d = 1 when final-stage domain d disagrees with majority (data or valid, any bit)
- err_count  out  CNT_W  saturating count of mismatch cycles
- err_clr  in  1  synchronous clear of err_count

## Operation
- Each domain d has its own registers {valid, data} per stage s = 0..DEPTH-1. There is no shared logic between domains except the voter inputs.
- Stage 0, domain d: data <= in_a_d OP in_b_d; valid <= in_valid_d. Registers load every cycle; valid is carried, not used as an enable.
- Stage s>0, domain d: loads voter_d(stage s-1 of domains 0,1,2). The voter is a bitwise 2-of-3 majority over {valid, data}, with one voter instance per domain per stage.
- Outputs: out_d / out_valid_d = voter_d(final stage), combinational from the final-stage registers.
- err_domain[d] = |(final_d XOR majority(final_0, final_1, final_2)), computed over {valid, data}. It is combinational, and more than one bit may be set when different bits have different minorities.
- err_count, per rising edge:
  - if err_clr = 1: count <= 0; clear wins over increment;
  - else if err_domain != 0 and count < 2^CNT_W-1: count <= count+1;
  - at the maximum value the count holds.
- Upsets confined to one domain in stages 0..DEPTH-2 are corrected by the next voter. They are not counted; only final-stage disagreement is counted.
- Reset (rst = 1 at an edge):
  - all stage registers go to 0 (data and valid), and err_count goes to 0;
  - in-flight data is discarded, including when reset is asserted mid-stream;
  - rst has priority over err_clr and over any increment.

## Timing
- Latency: inputs sampled at edge k appear on out_d / out_valid_d after edge k+DEPTH-1 settles, i.e. DEPTH edges after presentation. Throughput is 1 per cycle.
- Cycle after reset: out_* = 0, out_valid_* = 0, err_domain = 0, err_count = 0.
- err_domain is valid in the same cycle as the final-stage contents it describes. err_count reflects that cycle one edge later.
- Voters are purely combinational, with no added register stage.

## Test plan
- AND, WIDTH=8, DEPTH=2, all domains: a=0xF0, b=0x3C, valid=1 for one cycle -> out_0..2 = 0x30 and out_valid_0..2 = 1 exactly 2 edges later, then valid returns to 0; err_domain = 0; err_count = 0.
- DEPTH=2 scrub: domain 1 a=0xFF while others use 0xF0, b=0x3C -> out_0..2 = 0x30; err_domain stays 0; err_count = 0 (masked at the stage-1 voter).
- DEPTH=1, XOR: domain 2 a=0x01 while others use 0x00, b=0x00 -> out_0..2 = 0x00; err_domain = 3'b100 for one cycle; err_count = 1 on the next edge.
- CNT_W=2: domain 0 faulted for 5 consecutive final-stage cycles -> err_count sequence 1, 2, 3, 3, 3. Then err_clr=1 in a faulty cycle -> err_count = 0, not 1.
- Reset mid-stream, DEPTH=3: a stream of valid data, with rst=1 for one edge while 3 items are in flight -> next cycle out_*=0, out_valid_*=0, err_count=0; no stale item emerges afterwards.
- OR, WIDTH=8: a=0x0F, b=0xA0 on all domains with in_valid_1 = 0 only -> out = 0xAF, out_valid_0..2 = 1; err_domain = 3'b010 only if DEPTH=1, otherwise 0.
